// File: rtl/burst_ram_masked.sv
// Burst DRAM front-end model: init delay, latency-delayed read bursts and
// byte-masked write bursts with wrap-around addressing over a 2^DEPTH_BITWIDTH word array.
module burst_ram_masked #(
    parameter string DATA_FILE                = "",
    parameter int    DATA_WIDTH               = 64,
    parameter int    DEPTH_BITWIDTH           = 4,
    parameter int    BURST_COUNT              = 4,
    parameter int    CYCLES_BEFORE_DATA_VALID = 6,
    parameter int    CYCLES_BEFORE_INITIATED  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd,
    input  logic                      cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   data_mask,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_data_valid,
    output logic                      init_calib,
    output logic                      busy
);
    localparam int NBYTES  = DATA_WIDTH / 8;
    localparam int WORDS   = 1 << DEPTH_BITWIDTH;
    localparam int CNT_MAX = (CYCLES_BEFORE_INITIATED > CYCLES_BEFORE_DATA_VALID) ?
                             CYCLES_BEFORE_INITIATED : CYCLES_BEFORE_DATA_VALID;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BEAT_W  = $clog2(BURST_COUNT + 1);

    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(CYCLES_BEFORE_INITIATED - 1);
    localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(CYCLES_BEFORE_DATA_VALID - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_END  = BEAT_W'(BURST_COUNT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_COUNT - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_WAIT,
        S_RD_BURST,
        S_WR_BURST
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [BEAT_W-1:0]         r_beat;
    logic [DEPTH_BITWIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_mem [WORDS];
    logic [DATA_WIDTH-1:0]     r_rd_data;
    logic                      r_valid;
    logic                      r_init;
    logic                      r_busy;

    logic                      w_accept;
    logic                      w_we;
    logic [DEPTH_BITWIDTH-1:0] w_waddr;

    assign w_accept = cmd_en && !r_busy && r_init;
    // Beat 0 of a write lands on the accepting edge using the live address.
    assign w_we     = (w_accept && cmd) || (r_state == S_WR_BURST);
    assign w_waddr  = (r_state == S_WR_BURST) ? r_addr : addr;

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (!data_mask[i]) begin
                    r_mem[w_waddr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_beat    <= '0;
            r_addr    <= '0;
            r_rd_data <= '0;
            r_valid   <= 1'b0;
            r_init    <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_cnt == INIT_LAST) begin
                        r_state <= S_IDLE;
                        r_init  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        if (cmd) begin
                            if (BURST_COUNT > 1) begin
                                r_state <= S_WR_BURST;
                                r_busy  <= 1'b1;
                                r_addr  <= addr + 1'b1;
                                r_beat  <= BEAT_ONE;
                            end
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_busy  <= 1'b1;
                            r_addr  <= addr;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == LAT_LAST) begin
                        r_state   <= S_RD_BURST;
                        r_rd_data <= r_mem[r_addr];
                        r_valid   <= 1'b1;
                        r_addr    <= r_addr + 1'b1;
                        r_beat    <= BEAT_ONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_BURST: begin
                    if (r_beat == BEAT_END) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rd_data <= r_mem[r_addr];
                        r_addr    <= r_addr + 1'b1;
                        r_beat    <= r_beat + 1'b1;
                    end
                end
                S_WR_BURST: begin
                    r_addr <= r_addr + 1'b1;
                    r_beat <= r_beat + 1'b1;
                    if (r_beat == BEAT_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_valid;
    assign init_calib    = r_init;
    assign busy          = r_busy;
endmodule

// File: tb/tb_burst_ram_masked.sv
// Bench for burst_ram_masked: directed scenarios plus random bursts checked
// cycle by cycle against a word-array reference model.
module tb_burst_ram_masked;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam int B  = 4;
    localparam int L  = 6;
    localparam int NI = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd = 1'b0;
    logic          cmd_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [7:0]    data_mask = '0;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          init_calib;
    logic          busy;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] wd [B];
    logic [7:0]    wm [B];

    burst_ram_masked #(
        .DATA_FILE(""),
        .DATA_WIDTH(DW),
        .DEPTH_BITWIDTH(AW),
        .BURST_COUNT(B),
        .CYCLES_BEFORE_DATA_VALID(L),
        .CYCLES_BEFORE_INITIATED(NI)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .cmd_en(cmd_en),
        .addr(addr),
        .wr_data(wr_data),
        .data_mask(data_mask),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .init_calib(init_calib),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [7:0] m);
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i] ? old[8*i +: 8] : d[8*i +: 8];
        return r;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        chk("wait_idle", {63'd0, busy}, 64'd0);
    endtask

    // Counts NI edges after reset release; cmd_en is held high throughout and must be ignored.
    task automatic init_seq(input logic wr);
        cmd_en    = 1'b1;
        cmd       = wr;
        addr      = 4'd4;
        wr_data   = {$urandom, $urandom};
        data_mask = 8'h00;
        for (int e = 1; e <= NI; e++) begin
            step();
            chk("init_calib", {63'd0, init_calib}, {63'd0, (e == NI)});
            chk("init_busy", {63'd0, busy}, {63'd0, (e != NI)});
            chk("init_valid", {63'd0, rd_data_valid}, 64'd0);
        end
        cmd_en = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a);
        wait_idle();
        cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = wd[0]; data_mask = wm[0];
        step();
        cmd_en = 1'b0;
        for (int j = 1; j < B; j++) begin
            chk("wr_busy", {63'd0, busy}, 64'd1);
            chk("wr_valid", {63'd0, rd_data_valid}, 64'd0);
            wr_data = wd[j]; data_mask = wm[j];
            step();
        end
        chk("wr_busy_end", {63'd0, busy}, 64'd0);
        chk("wr_rd_hold", rd_data, last_rd);
        for (int j = 0; j < B; j++) begin
            int idx = (int'(a) + j) % 16;
            ref_mem[idx] = merge(ref_mem[idx], wd[j], wm[j]);
        end
    endtask

    // inject: pulse a write to addr 0 mid-read; stop_e: return after that many post-accept edges.
    task automatic do_read(input logic [AW-1:0] a, input bit inject, input int stop_e);
        logic exp_v;
        wait_idle();
        cmd = 1'b0; cmd_en = 1'b1; addr = a;
        step();
        cmd_en = 1'b0;
        chk("rd_busy_accept", {63'd0, busy}, 64'd1);
        for (int e = 1; e <= L + B; e++) begin
            if (inject && e == 2) begin
                cmd = 1'b1; cmd_en = 1'b1; addr = '0;
                wr_data = {$urandom, $urandom}; data_mask = 8'h00;
            end
            if (inject && e == 3) cmd_en = 1'b0;
            step();
            exp_v = (e >= L) && (e < L + B);
            chk("rd_valid", {63'd0, rd_data_valid}, {63'd0, exp_v});
            if (exp_v) last_rd = ref_mem[(int'(a) + e - L) % 16];
            chk("rd_data", rd_data, last_rd);
            chk("rd_busy", {63'd0, busy}, {63'd0, (e < L + B)});
            if (e == stop_e) return;
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        // Reset state and init timing, with a read strobe that must be ignored.
        repeat (3) step();
        chk("rst_init", {63'd0, init_calib}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        chk("rst_valid", {63'd0, rd_data_valid}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        rst_n = 1'b1;
        init_seq(1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("ignored_read_valid", {63'd0, rd_data_valid}, 64'd0);
        end

        // Fill every word so all later reads are defined.
        for (int blk = 0; blk < 4; blk++) begin
            for (int j = 0; j < B; j++) begin wd[j] = {$urandom, $urandom}; wm[j] = 8'h00; end
            do_write(AW'(blk * 4));
        end

        wd[0] = {8{8'h11}}; wd[1] = {8{8'h22}}; wd[2] = {8{8'h33}}; wd[3] = {8{8'h44}};
        for (int j = 0; j < B; j++) wm[j] = 8'h00;
        do_write(4'd4);
        do_read(4'd4, 1'b0, 100);

        for (int j = 0; j < B; j++) begin wd[j] = {64{1'b1}}; wm[j] = 8'hF0; end
        do_write(4'd4);
        do_read(4'd4, 1'b0, 100);

        wd[0] = 64'hE0E0_0101_2323_4545; wd[1] = 64'hF1F1_0202_3434_5656;
        wd[2] = 64'h0A0A_B0B0_C0C0_D0D0; wd[3] = 64'h1B1B_C1C1_D1D1_E1E1;
        for (int j = 0; j < B; j++) wm[j] = 8'h00;
        do_write(4'd14);
        do_read(4'd14, 1'b0, 100);

        do_read(4'd0, 1'b1, 100);
        do_read(4'd0, 1'b0, 100);

        for (int it = 0; it < 24; it++) begin
            ra = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < B; j++) begin
                    wd[j] = {$urandom, $urandom};
                    wm[j] = 8'($urandom_range(0, 255));
                end
                do_write(ra);
            end else begin
                do_read(ra, 1'b0, 100);
            end
        end

        // Reset between beats 1 and 2 of a read.
        do_read(4'd4, 1'b0, L + 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrd_rst_valid", {63'd0, rd_data_valid}, 64'd0);
        chk("midrd_rst_busy", {63'd0, busy}, 64'd1);
        chk("midrd_rst_init", {63'd0, init_calib}, 64'd0);
        chk("midrd_rst_rd_data", rd_data, 64'd0);
        last_rd = '0;
        step();
        step();
        rst_n = 1'b1;
        init_seq(1'b1);
        do_read(4'd4, 1'b0, 100);
        do_read(4'd14, 1'b0, 100);

        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
